// File: rtl/intlev_pkg.sv
// Shared types and constants for the per-level interrupt source arbiter.
// Holds the arbiter state encoding, the idle vector code and the minimum HOLD time.
package intlev_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OFFER = 2'd1,
    XFER  = 2'd2,
    HOLD  = 2'd3
  } state_e;

  localparam logic [7:0] INTVEC_NONE = 8'h01;
  localparam int         HOLD_MIN    = 2;

  // Device vectors are longword aligned, so the two low bits are always cleared.
  function automatic logic [7:0] maskVec(input logic [7:0] v);
    return {v[7:2], 2'b00};
  endfunction

endpackage

// File: rtl/pri_enc8.sv
// Lowest-set-bit priority encoder over eight request lines.
// Index 0 has the highest priority; any_o flags that at least one line is set.
module pri_enc8 (
  input  logic [7:0] req_i,
  output logic [2:0] idx_o,
  output logic       any_o
);

  // Scan from the top down so the lowest set index is the last one written.
  always_comb begin
    idx_o = 3'd0;
    any_o = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      if (req_i[i]) begin
        idx_o = 3'(i);
        any_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/intlev_arb.sv
// Interrupt source arbiter for one BR level: picks the highest-priority pending
// device, offers its vector to the level controller and acknowledges the winner.
module intlev_arb
  import intlev_pkg::*;
#(
  parameter int NSRC = 4
) (
  input  logic              CLOCK,
  input  logic              RESET,
  input  logic              init_in_h,
  input  logic [NSRC-1:0]   req_h,
  input  logic [8*NSRC-1:0] vec_in,
  input  logic              intr_in_h,
  input  logic              ssyn_in_h,
  output logic [7:0]        intvec,
  output logic [NSRC-1:0]   ack_h,
  output logic              busy_h
);

  localparam logic [1:0] HOLD_MIN_C = 2'(HOLD_MIN);

  state_e          state_q;
  logic [2:0]      sel_q;
  logic [7:0]      vecLat_q;
  logic [1:0]      holdCnt_q;
  logic [7:0]      intvec_q;
  logic [NSRC-1:0] ack_q;
  logic            busy_q;

  logic [7:0]      reqPad;
  logic [63:0]     vecPad;
  logic [2:0]      encIdx;
  logic            encAny;
  logic [7:0]      offerVec_d;
  logic [NSRC-1:0] ackOneHot_d;

  // Widen the source buses to the full eight slots; absent sources read as idle.
  always_comb begin
    reqPad             = '0;
    reqPad[NSRC-1:0]   = req_h;
    vecPad             = '0;
    vecPad[8*NSRC-1:0] = vec_in;
  end

  pri_enc8 u_enc (
    .req_i (reqPad),
    .idx_o (encIdx),
    .any_o (encAny)
  );

  assign offerVec_d = maskVec(vecPad[{encIdx, 3'b000} +: 8]);

  always_comb begin
    ackOneHot_d = '0;
    for (int i = 0; i < NSRC; i++) begin
      ackOneHot_d[i] = (sel_q == 3'(i));
    end
  end

  // INIT is a synchronous clear that overrides every transition, including a pending ack.
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      state_q   <= IDLE;
      sel_q     <= 3'd0;
      vecLat_q  <= 8'h00;
      holdCnt_q <= 2'd0;
      intvec_q  <= INTVEC_NONE;
      ack_q     <= '0;
      busy_q    <= 1'b0;
    end else if (init_in_h) begin
      state_q   <= IDLE;
      sel_q     <= 3'd0;
      vecLat_q  <= 8'h00;
      holdCnt_q <= 2'd0;
      intvec_q  <= INTVEC_NONE;
      ack_q     <= '0;
      busy_q    <= 1'b0;
    end else begin
      ack_q <= '0;
      unique case (state_q)
        IDLE: begin
          if (encAny) begin
            state_q  <= OFFER;
            sel_q    <= encIdx;
            vecLat_q <= offerVec_d;
            intvec_q <= offerVec_d;
            busy_q   <= 1'b1;
          end
        end
        // Once INTR is up the interrupt is committed, even if the request drops now.
        OFFER: begin
          if (intr_in_h) begin
            state_q <= XFER;
          end else if (!reqPad[sel_q]) begin
            state_q  <= IDLE;
            intvec_q <= INTVEC_NONE;
            busy_q   <= 1'b0;
          end
        end
        XFER: begin
          if (!intr_in_h) begin
            state_q   <= HOLD;
            ack_q     <= ackOneHot_d;
            intvec_q  <= INTVEC_NONE;
            holdCnt_q <= 2'd1;
          end
        end
        // Counter saturates at the minimum; the exit then waits only for SSYN to drop.
        HOLD: begin
          if (holdCnt_q >= HOLD_MIN_C && !ssyn_in_h) begin
            state_q   <= IDLE;
            holdCnt_q <= 2'd0;
            busy_q    <= 1'b0;
          end else if (holdCnt_q < HOLD_MIN_C) begin
            holdCnt_q <= holdCnt_q + 2'd1;
          end
        end
        default: begin
          state_q  <= IDLE;
          intvec_q <= INTVEC_NONE;
          busy_q   <= 1'b0;
        end
      endcase
    end
  end

  assign intvec = intvec_q;
  assign ack_h  = ack_q;
  assign busy_h = busy_q;

endmodule

// File: tb/tb_intlev_arb.sv
// Directed, table-driven bench for intlev_arb with four sources.
// Each row is driven before a clock edge and its expected outputs are checked just after it.
module tb_intlev_arb;

  localparam int NSRC = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        init;
  logic [3:0]  req;
  logic [31:0] vec;
  logic        intr;
  logic        ssyn;
  logic [7:0]  intvec;
  logic [3:0]  ack;
  logic        busy;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  intlev_arb #(.NSRC(NSRC)) dut (
    .CLOCK     (clk),
    .RESET     (rst),
    .init_in_h (init),
    .req_h     (req),
    .vec_in    (vec),
    .intr_in_h (intr),
    .ssyn_in_h (ssyn),
    .intvec    (intvec),
    .ack_h     (ack),
    .busy_h    (busy)
  );

  typedef struct {
    logic        init;
    logic [3:0]  req;
    logic [31:0] vec;
    logic        intr;
    logic        ssyn;
    logic [7:0]  expVec;
    logic [3:0]  expAck;
    logic        expBusy;
  } row_t;

  row_t rows[$];

  task automatic addRow(input logic i, input logic [3:0] r, input logic [31:0] v,
                        input logic it, input logic s, input logic [7:0] eV,
                        input logic [3:0] eA, input logic eB);
    row_t x;
    x.init = i; x.req = r; x.vec = v; x.intr = it; x.ssyn = s;
    x.expVec = eV; x.expAck = eA; x.expBusy = eB;
    rows.push_back(x);
  endtask

  task automatic applyStimulus(input logic i, input logic [3:0] r, input logic [31:0] v,
                               input logic it, input logic s);
    init = i; req = r; vec = v; intr = it; ssyn = s;
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] eV,
                             input logic [3:0] eA, input logic eB);
    checks++;
    if (intvec !== eV) begin
      errors++;
      $display("[TB] FAIL %s intvec got=%h want=%h", tag, intvec, eV);
    end
    checks++;
    if (ack !== eA) begin
      errors++;
      $display("[TB] FAIL %s ack_h got=%b want=%b", tag, ack, eA);
    end
    checks++;
    if (busy !== eB) begin
      errors++;
      $display("[TB] FAIL %s busy_h got=%b want=%b", tag, busy, eB);
    end
  endtask

  localparam logic [31:0] V1 = 32'h0034_0000;  // src2 = 8'o064
  localparam logic [31:0] V2 = 32'hC000_4000;  // src1 = 8'o100, src3 = 8'o300
  localparam logic [31:0] V3 = 32'h0034_0010;  // src0 = 8'o020, src2 = 8'o064
  localparam logic [31:0] V4 = 32'h3700_0000;  // src3 = 8'o067
  localparam logic [31:0] V5 = 32'hFC00_0000;  // src3 changed while committed

  initial begin
    // single source, full interrupt with INTR high for five cycles
    addRow(0, 4'b0100, V1, 0, 0, 8'h34, 4'b0000, 1);
    for (int k = 0; k < 2; k++) addRow(0, 4'b0100, V1, 1, 0, 8'h34, 4'b0000, 1);
    for (int k = 0; k < 3; k++) addRow(0, 4'b0100, V1, 1, 1, 8'h34, 4'b0000, 1);
    addRow(0, 4'b0100, V1, 0, 1, 8'h01, 4'b0100, 1);
    addRow(0, 4'b0000, V1, 0, 0, 8'h01, 4'b0000, 1);
    addRow(0, 4'b0000, V1, 0, 0, 8'h01, 4'b0000, 0);
    addRow(0, 4'b0000, V1, 0, 0, 8'h01, 4'b0000, 0);
    // priority: source 1 before source 3
    addRow(0, 4'b1010, V2, 0, 0, 8'h40, 4'b0000, 1);
    addRow(0, 4'b1010, V2, 1, 0, 8'h40, 4'b0000, 1);
    addRow(0, 4'b1010, V2, 0, 1, 8'h01, 4'b0010, 1);
    addRow(0, 4'b1000, V2, 0, 0, 8'h01, 4'b0000, 1);
    addRow(0, 4'b1000, V2, 0, 0, 8'h01, 4'b0000, 0);
    addRow(0, 4'b1000, V2, 0, 0, 8'hC0, 4'b0000, 1);
    addRow(0, 4'b1000, V2, 1, 0, 8'hC0, 4'b0000, 1);
    addRow(0, 4'b1000, V2, 0, 0, 8'h01, 4'b1000, 1);
    addRow(0, 4'b0000, V2, 0, 0, 8'h01, 4'b0000, 1);
    addRow(0, 4'b0000, V2, 0, 0, 8'h01, 4'b0000, 0);
    // withdrawal, and no preemption inside OFFER
    addRow(0, 4'b0001, V3, 0, 0, 8'h10, 4'b0000, 1);
    addRow(0, 4'b0000, V3, 0, 0, 8'h01, 4'b0000, 0);
    addRow(0, 4'b0000, V3, 0, 0, 8'h01, 4'b0000, 0);
    addRow(0, 4'b0100, V3, 0, 0, 8'h34, 4'b0000, 1);
    addRow(0, 4'b0101, V3, 0, 0, 8'h34, 4'b0000, 1);
    addRow(0, 4'b0001, V3, 0, 0, 8'h01, 4'b0000, 0);
    addRow(0, 4'b0001, V3, 0, 0, 8'h10, 4'b0000, 1);
    addRow(0, 4'b0000, V3, 0, 0, 8'h01, 4'b0000, 0);
    // race: request falls on the same edge INTR rises
    addRow(0, 4'b0001, V3, 0, 0, 8'h10, 4'b0000, 1);
    addRow(0, 4'b0000, V3, 1, 0, 8'h10, 4'b0000, 1);
    addRow(0, 4'b0000, V3, 1, 0, 8'h10, 4'b0000, 1);
    addRow(0, 4'b0000, V3, 0, 0, 8'h01, 4'b0001, 1);
    addRow(0, 4'b0000, V3, 0, 0, 8'h01, 4'b0000, 1);
    addRow(0, 4'b0000, V3, 0, 0, 8'h01, 4'b0000, 0);
    // INIT mid-transfer, and INIT beating a fresh request in IDLE
    addRow(0, 4'b0001, V3, 0, 0, 8'h10, 4'b0000, 1);
    addRow(0, 4'b0001, V3, 1, 0, 8'h10, 4'b0000, 1);
    addRow(1, 4'b0001, V3, 1, 0, 8'h01, 4'b0000, 0);
    addRow(1, 4'b0001, V3, 0, 0, 8'h01, 4'b0000, 0);
    addRow(0, 4'b0000, V3, 0, 0, 8'h01, 4'b0000, 0);
    addRow(0, 4'b0000, V3, 0, 0, 8'h01, 4'b0000, 0);
    // HOLD stretched by SSYN, low vector bits masked, late vector change ignored
    addRow(0, 4'b1000, V4, 0, 0, 8'h34, 4'b0000, 1);
    addRow(0, 4'b1000, V5, 1, 0, 8'h34, 4'b0000, 1);
    addRow(0, 4'b1000, V5, 0, 1, 8'h01, 4'b1000, 1);
    for (int k = 0; k < 6; k++) addRow(0, 4'b0000, V5, 0, 1, 8'h01, 4'b0000, 1);
    addRow(0, 4'b0000, V5, 0, 0, 8'h01, 4'b0000, 0);
    addRow(0, 4'b0000, V5, 0, 0, 8'h01, 4'b0000, 0);

    rst = 1'b1;
    applyStimulus(0, 4'b0000, 32'h0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset", 8'h01, 4'b0000, 0);
    rst = 1'b0;

    foreach (rows[i]) begin
      applyStimulus(rows[i].init, rows[i].req, rows[i].vec, rows[i].intr, rows[i].ssyn);
      @(posedge clk);
      #1;
      checkOutput($sformatf("row%0d", i), rows[i].expVec, rows[i].expAck, rows[i].expBusy);
    end

    // asynchronous RESET while OFFER is active takes effect without a clock edge
    applyStimulus(0, 4'b0001, V3, 0, 0);
    @(posedge clk);
    #1;
    checkOutput("pre_async", 8'h10, 4'b0000, 1);
    #2 rst = 1'b1;
    #1;
    checkOutput("async_rst", 8'h01, 4'b0000, 0);
    req = 4'b0000;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("post_async", 8'h01, 4'b0000, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
